// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and scanout types.
// 640x480@60 timing with a 320x240 RGB444 framebuffer.
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int H_FP       = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE   = 480;
    localparam int V_FP       = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int FB_WIDTH   = 320;
    localparam int FB_HEIGHT  = 240;
    localparam int DATA_WIDTH = 12;
    localparam int ADDR_WIDTH = 17;
    localparam int CNT_W      = 10;

    typedef logic [11:0] rgb444_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } vid_ctl_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel/line counters with stage-0 active, sync and blank decode.
// Sync outputs are active-high here; polarity is applied at the pins.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-2:0] col,
    output logic             v_odd,
    output logic             h_wrap,
    output logic             frame_wrap,
    output logic             vb_enter,
    output logic             active,
    output logic             hsync,
    output logic             vsync,
    output logic             vblank
);

    localparam logic [CNT_W-1:0] HA     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_ON  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_OFF = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] VA     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VA_M1  = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] VS_ON  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_OFF = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign h_wrap     = (h_cnt == H_LAST);
    assign frame_wrap = h_wrap && (v_cnt == V_LAST);
    // Edge on which the counters step into (0, V_ACTIVE)
    assign vb_enter   = h_wrap && (v_cnt == VA_M1);
    assign col        = h_cnt[CNT_W-1:1];
    assign v_odd      = v_cnt[0];
    assign active     = (h_cnt < HA) && (v_cnt < VA);
    assign hsync      = (h_cnt >= HS_ON) && (h_cnt < HS_OFF);
    assign vsync      = (v_cnt >= VS_ON) && (v_cnt < VS_OFF);
    assign vblank     = (v_cnt >= VA);

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer read-side scanout: 2x2 doubled addressing, BRAM latency
// alignment of sync/de/colour, and vblank-time front/back buffer swap.
module framebuffer_scanout
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int   H_FP       = vga_pkg::H_FP,
    parameter int   H_SYNC     = vga_pkg::H_SYNC,
    parameter int   H_BP       = vga_pkg::H_BP,
    parameter int   V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int   V_FP       = vga_pkg::V_FP,
    parameter int   V_SYNC     = vga_pkg::V_SYNC,
    parameter int   V_BP       = vga_pkg::V_BP,
    parameter int   FB_WIDTH   = vga_pkg::FB_WIDTH,
    parameter int   FB_HEIGHT  = vga_pkg::FB_HEIGHT,
    parameter int   DATA_WIDTH = vga_pkg::DATA_WIDTH,
    parameter int   ADDR_WIDTH = vga_pkg::ADDR_WIDTH,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic                  vga_de,
    output logic [DATA_WIDTH-1:0] vga_rgb,
    output logic                  vblank,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  front_buf
);

    localparam logic [ADDR_WIDTH-1:0] FBW = ADDR_WIDTH'(FB_WIDTH);

    if (2 * FB_WIDTH != H_ACTIVE || 2 * FB_HEIGHT != V_ACTIVE) begin : g_bad_geom
        $error("framebuffer must be exactly half the active raster");
    end

    logic [CNT_W-2:0]      col;
    logic                  v_odd;
    logic                  h_wrap;
    logic                  frame_wrap;
    logic                  vb_enter;
    logic                  active;
    logic                  hsync;
    logic                  vsync;
    logic [ADDR_WIDTH-1:0] line_base;
    vid_ctl_t              s0;
    vid_ctl_t              d1;
    vid_ctl_t              d2;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .col        (col),
        .v_odd      (v_odd),
        .h_wrap     (h_wrap),
        .frame_wrap (frame_wrap),
        .vb_enter   (vb_enter),
        .active     (active),
        .hsync      (hsync),
        .vsync      (vsync),
        .vblank     (vblank)
    );

    assign s0 = '{de: active, hs: hsync, vs: vsync};

    // Each framebuffer row is reused for an even/odd line pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_base <= '0;
            raddr     <= '0;
        end else begin
            if (s0.de)
                raddr <= line_base + ADDR_WIDTH'(col);
            if (frame_wrap)
                line_base <= '0;
            else if (h_wrap && v_odd && !vblank)
                line_base <= line_base + FBW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1        <= '0;
            d2        <= '0;
            vga_de    <= 1'b0;
            vga_hsync <= ~SYNC_POL;
            vga_vsync <= ~SYNC_POL;
            vga_rgb   <= '0;
        end else begin
            d1        <= s0;
            d2        <= d1;
            vga_de    <= d2.de;
            vga_hsync <= d2.hs ? SYNC_POL : ~SYNC_POL;
            vga_vsync <= d2.vs ? SYNC_POL : ~SYNC_POL;
            vga_rgb   <= d2.de ? rdata : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_ack  <= 1'b0;
            front_buf <= 1'b0;
        end else begin
            swap_ack <= vb_enter && swap_req;
            if (vb_enter && swap_req)
                front_buf <= ~front_buf;
        end
    end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout on a reduced raster
// (32x16 visible, 48x22 total, 16x8 framebuffer).
module tb_framebuffer_scanout;
    import vga_pkg::*;

    localparam int TH = 48;
    localparam int TV = 22;
    localparam int FR = TH * TV;

    logic        clk;
    logic        rst;
    logic [16:0] raddr;
    logic [11:0] rdata;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_de;
    logic [11:0] vga_rgb;
    logic        vblank;
    logic        swap_req;
    logic        swap_ack;
    logic        front_buf;

    int cyc;
    int total;
    int passes;
    int bad_blank;

    framebuffer_scanout #(
        .H_ACTIVE   (32),
        .H_FP       (4),
        .H_SYNC     (8),
        .H_BP       (4),
        .V_ACTIVE   (16),
        .V_FP       (2),
        .V_SYNC     (2),
        .V_BP       (2),
        .FB_WIDTH   (16),
        .FB_HEIGHT  (8),
        .DATA_WIDTH (12),
        .ADDR_WIDTH (17),
        .SYNC_POL   (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raddr     (raddr),
        .rdata     (rdata),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_de    (vga_de),
        .vga_rgb   (vga_rgb),
        .vblank    (vblank),
        .swap_req  (swap_req),
        .swap_ack  (swap_ack),
        .front_buf (front_buf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rgb444_t pix(input logic [16:0] a);
        if (a == 17'd5)
            return 12'hABC;
        return a[11:0] ^ 12'h5A0;
    endfunction

    always @(posedge clk)
        rdata <= pix(raddr);

    always @(negedge clk)
        if (!rst && !vga_de && vga_rgb != 12'h000)
            bad_blank++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int t);
        if (t < cyc) begin
            total++;
            $error("FAIL goto target=%0d now=%0d", t, cyc);
        end
        while (cyc < t)
            step();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_raddr"}, 32'(raddr), 0);
        chk({tag, "_de"}, 32'(vga_de), 0);
        chk({tag, "_rgb"}, 32'(vga_rgb), 0);
        chk({tag, "_hs"}, 32'(vga_hsync), 1);
        chk({tag, "_vs"}, 32'(vga_vsync), 1);
        chk({tag, "_vblank"}, 32'(vblank), 0);
        chk({tag, "_ack"}, 32'(swap_ack), 0);
        chk({tag, "_fb"}, 32'(front_buf), 0);
    endtask

    initial begin
        total = 0;
        passes = 0;
        bad_blank = 0;
        cyc = 0;
        rst = 1'b1;
        swap_req = 1'b0;
        @(posedge clk);
        #1;
        chk_reset("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        goto(1);    chk("raddr_h0", 32'(raddr), 0);
                    chk("fb_init", 32'(front_buf), 0);
        goto(2);    chk("de_lat", 32'(vga_de), 0);
        goto(3);    chk("raddr_h2", 32'(raddr), 1);
                    chk("de_h0", 32'(vga_de), 1);
        goto(11);   chk("raddr_h10", 32'(raddr), 5);
        goto(13);   chk("rgb_h10", 32'(vga_rgb), 32'h0ABC);
                    chk("de_h10", 32'(vga_de), 1);
        goto(14);   chk("rgb_h11", 32'(vga_rgb), 32'h0ABC);
        goto(15);   chk("rgb_h12", 32'(vga_rgb), 32'h05A6);
        goto(32);   chk("raddr_h31", 32'(raddr), 15);
        goto(34);   chk("rgb_h31", 32'(vga_rgb), 32'h05AF);
                    chk("de_h31", 32'(vga_de), 1);
        goto(35);   chk("de_h32", 32'(vga_de), 0);
                    chk("rgb_h32", 32'(vga_rgb), 0);
        goto(38);   chk("hs_pre", 32'(vga_hsync), 1);
        goto(39);   chk("hs_first", 32'(vga_hsync), 0);
        goto(40);   chk("raddr_hold", 32'(raddr), 15);
        goto(46);   chk("hs_last", 32'(vga_hsync), 0);
        goto(47);   chk("hs_post", 32'(vga_hsync), 1);
        goto(49);   chk("raddr_v1", 32'(raddr), 0);
        goto(97);   chk("raddr_v2", 32'(raddr), 16);
        goto(5 * TH);
        swap_req = 1'b1;
        goto(15 * TH + 32); chk("raddr_last", 32'(raddr), 127);

        goto(16 * TH - 1);
        chk("vblank_pre", 32'(vblank), 0);
        chk("ack_pre", 32'(swap_ack), 0);
        chk("fb_pre", 32'(front_buf), 0);
        goto(16 * TH);
        chk("vblank_on", 32'(vblank), 1);
        chk("ack0", 32'(swap_ack), 1);
        chk("fb_swap0", 32'(front_buf), 1);
        swap_req = 1'b0;
        goto(16 * TH + 1);
        chk("ack0_pulse", 32'(swap_ack), 0);
        chk("fb_keep0", 32'(front_buf), 1);

        goto(18 * TH + 2); chk("vs_pre", 32'(vga_vsync), 1);
        goto(18 * TH + 3); chk("vs_first", 32'(vga_vsync), 0);
        goto(20 * TH + 2); chk("vs_last", 32'(vga_vsync), 0);
        goto(20 * TH + 3); chk("vs_post", 32'(vga_vsync), 1);

        goto(FR);     chk("vblank_off", 32'(vblank), 0);
        goto(FR + 1); chk("raddr_f1", 32'(raddr), 0);

        goto(FR + 16 * TH);
        chk("ack1_none", 32'(swap_ack), 0);
        goto(FR + 16 * TH + 1);
        swap_req = 1'b1;
        goto(FR + 16 * TH + 2);
        chk("ack1_late", 32'(swap_ack), 0);
        chk("fb_late", 32'(front_buf), 1);
        goto(2 * FR + 16 * TH);
        chk("ack2", 32'(swap_ack), 1);
        chk("fb_swap2", 32'(front_buf), 0);
        swap_req = 1'b0;
        goto(2 * FR + 16 * TH + 1);
        chk("ack2_pulse", 32'(swap_ack), 0);

        goto(3 * FR + 16 * TH);
        chk("ack3_noreq", 32'(swap_ack), 0);
        chk("fb_noreq", 32'(front_buf), 0);
        swap_req = 1'b1;
        goto(4 * FR + 16 * TH);
        chk("ack4", 32'(swap_ack), 1);
        chk("fb_swap4", 32'(front_buf), 1);
        swap_req = 1'b0;

        goto(5 * FR + 10 * TH + 20);
        chk("raddr_mid", 32'(raddr), 89);
        chk("de_mid", 32'(vga_de), 1);
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        goto(1);    chk("raddr_rel", 32'(raddr), 0);
                    chk("fb_rel", 32'(front_buf), 0);
        goto(3);    chk("raddr_rel_h2", 32'(raddr), 1);
                    chk("de_rel", 32'(vga_de), 1);

        chk("blank_rgb", 32'(bad_blank), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
